// File: rtl/sysarr_pkg.sv
// Shared definitions for the systolic array result drain and the input skew FIFOs.
package sysarr_pkg;

    localparam int SYSARR_DIM  = 8;
    localparam int SYSARR_ROWS = 8;
    localparam int SYSARR_BITS = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/drain_lane.sv
// One column of the result buffer: write counter, ROWS-deep storage and row read port.
module drain_lane #(
    parameter int ROWS = 8,
    parameter int BITS = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      we,
    input  logic [BITS-1:0]           din,
    input  logic [$clog2(ROWS)-1:0]   rd_row,
    output logic [BITS-1:0]           rd_word,
    output logic                      full,
    output logic                      last_wr
);

    localparam int RW  = $clog2(ROWS);
    localparam int WCW = $clog2(ROWS + 1);

    logic [BITS-1:0] col [ROWS];
    logic [WCW-1:0]  wc;

    assign full    = (wc == WCW'(ROWS));
    assign last_wr = we && (wc == WCW'(ROWS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wc <= '0;
            for (int r = 0; r < ROWS; r++) col[r] <= '0;
        end else if (clr) begin
            wc <= '0;
            for (int r = 0; r < ROWS; r++) col[r] <= '0;
        end else if (we && !full) begin
            for (int r = 0; r < ROWS; r++) begin
                if (wc == WCW'(r)) col[r] <= din;
            end
            wc <= wc + 1'b1;
        end
    end

    // Rows that do not exist (non-power-of-2 ROWS) read as zero.
    always_comb begin
        rd_word = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (rd_row == RW'(r)) rd_word = col[r];
        end
    end

endmodule

// File: rtl/sysarr_drain.sv
// Result drain: realigns skewed lane outputs into a ROWS x DIM buffer and serves
// single elements over a registered request/response read port.
module sysarr_drain
    import sysarr_pkg::*;
#(
    parameter int DIM  = SYSARR_DIM,
    parameter int ROWS = SYSARR_ROWS,
    parameter int BITS = SYSARR_BITS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      in_valid,
    input  logic [DIM*BITS-1:0]       in_data,
    input  logic                      rd_req,
    input  logic [$clog2(ROWS)-1:0]   rd_row,
    input  logic [$clog2(DIM)-1:0]    rd_col,
    output logic                      rd_valid,
    output logic [BITS-1:0]           rd_data,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow
);

    localparam int CW = $clog2(DIM);

    state_t          state;
    logic [DIM-1:0]  vp;
    logic [DIM-1:1]  vp_q;
    logic [DIM-1:0]  lane_full;
    logic [DIM-1:0]  lane_last;
    logic [BITS-1:0] lane_word [DIM];
    logic [BITS-1:0] rd_mux;
    logic            accept;
    logic            drop;
    logic            run_done;

    assign accept = (state == ST_CAPTURE) && in_valid && !start && !lane_full[0];
    assign drop   = (state == ST_CAPTURE) && in_valid && !start &&  lane_full[0];
    assign vp     = {vp_q, accept};

    // Lanes finish in order, so the run completes in the cycle where every
    // lane is either already full or performing its final write.
    assign run_done = (state == ST_CAPTURE) && (&(lane_full | lane_last));

    for (genvar i = 0; i < DIM; i++) begin : g_lane
        drain_lane #(
            .ROWS (ROWS),
            .BITS (BITS)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (start),
            .we      (vp[i]),
            .din     (in_data[i*BITS +: BITS]),
            .rd_row  (rd_row),
            .rd_word (lane_word[i]),
            .full    (lane_full[i]),
            .last_wr (lane_last[i])
        );
    end

    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < DIM; c++) begin
            if (rd_col == CW'(c)) rd_mux = lane_word[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            vp_q     <= '0;
        end else if (start) begin
            state    <= ST_CAPTURE;
            busy     <= 1'b1;
            done     <= 1'b0;
            overflow <= 1'b0;
            vp_q     <= '0;
        end else begin
            vp_q <= vp[DIM-2:0];
            if (drop) overflow <= 1'b1;
            if (run_done) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) rd_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_sysarr_drain.sv
// Directed and randomized bench for sysarr_drain against a cycle-stamped row model.
module tb_sysarr_drain;

    localparam int DIM  = 4;
    localparam int ROWS = 4;
    localparam int BITS = 16;
    localparam int RW   = $clog2(ROWS);
    localparam int CW   = $clog2(DIM);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                in_valid = 1'b0;
    logic [DIM*BITS-1:0] in_data = '0;
    logic                rd_req = 1'b0;
    logic [RW-1:0]       rd_row = '0;
    logic [CW-1:0]       rd_col = '0;
    logic                rd_valid;
    logic [BITS-1:0]     rd_data;
    logic                busy;
    logic                done;
    logic                overflow;

    sysarr_drain #(.DIM(DIM), .ROWS(ROWS), .BITS(BITS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .rd_req   (rd_req),
        .rd_row   (rd_row),
        .rd_col   (rd_col),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: rows accepted in the current run, stamped with their accept cycle.
    bit              m_started = 1'b0;
    int              m_nrows = 0;
    int              m_tacc [ROWS];
    logic [BITS-1:0] m_val [ROWS][DIM];
    bit              m_ovf = 1'b0;

    logic [BITS-1:0] exp_q[$];
    logic [BITS-1:0] exp_rd_data = '0;

    // pend[k][lane]: value lane drives k cycles from now (skewed stimulus).
    logic [BITS-1:0] pend [DIM][DIM];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit model_done();
        return m_started && (m_nrows == ROWS) && (cyc >= m_tacc[ROWS-1] + DIM);
    endfunction

    function automatic bit model_capture();
        return m_started && !model_done();
    endfunction

    // An element is visible to a read only if its lane wrote it at an earlier edge.
    function automatic logic [BITS-1:0] model_read(input int r, input int c);
        if (r < m_nrows && (m_tacc[r] + c) < cyc) return m_val[r][c];
        return '0;
    endfunction

    function automatic logic [DIM*BITS-1:0] mk_row(input int r);
        logic [DIM*BITS-1:0] v;
        for (int i = 0; i < DIM; i++) v[i*BITS +: BITS] = BITS'((r << 12) | (i << 8));
        return v;
    endfunction

    function automatic logic [DIM*BITS-1:0] rand_row();
        logic [DIM*BITS-1:0] v;
        for (int i = 0; i < DIM; i++) v[i*BITS +: BITS] = BITS'($urandom);
        return v;
    endfunction

    task automatic model_clear();
        m_started = 1'b0;
        m_nrows   = 0;
        m_ovf     = 1'b0;
        exp_q.delete();
        exp_rd_data = '0;
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
    task automatic step(input bit v, input bit st, input bit rq, input int rr, input int rc,
                        input logic [DIM*BITS-1:0] rowv);
        bit cap;
        for (int i = 0; i < DIM; i++) pend[i][i] = rowv[i*BITS +: BITS];
        for (int i = 0; i < DIM; i++) in_data[i*BITS +: BITS] = pend[0][i];
        in_valid = v;
        start    = st;
        rd_req   = rq;
        rd_row   = RW'(rr);
        rd_col   = CW'(rc);
        @(negedge clk);
        cap = model_capture();
        chk("busy", busy, cap);
        chk("done", done, model_done());
        chk("overflow", overflow, m_ovf);
        if (exp_q.size() > 0) begin
            exp_rd_data = exp_q.pop_front();
            chk("rd_valid", rd_valid, 1);
        end else begin
            chk("rd_valid", rd_valid, 0);
        end
        chk("rd_data", rd_data, exp_rd_data);
        if (rq) exp_q.push_back(model_read(rr, rc));
        if (st) begin
            m_started = 1'b1;
            m_nrows   = 0;
            m_ovf     = 1'b0;
        end else if (v && cap) begin
            if (m_nrows < ROWS) begin
                m_tacc[m_nrows] = cyc;
                for (int i = 0; i < DIM; i++) m_val[m_nrows][i] = rowv[i*BITS +: BITS];
                m_nrows++;
            end else begin
                m_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < DIM - 1; k++) pend[k] = pend[k+1];
        for (int i = 0; i < DIM; i++) pend[DIM-1][i] = BITS'($urandom);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 0, 0, rand_row());
    endtask

    task automatic read_all();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < DIM; c++) step(1'b0, 1'b0, 1'b1, r, c, rand_row());
        idle(1);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        model_clear();
        in_valid = 1'b0;
        start    = 1'b0;
        rd_req   = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    bit rv;
    bit rs;
    bit rq;

    initial begin
        for (int k = 0; k < DIM; k++)
            for (int i = 0; i < DIM; i++) pend[k][i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_busy", busy, 0);
        chk("init_done", done, 0);
        chk("init_overflow", overflow, 0);
        chk("init_rd_valid", rd_valid, 0);
        chk("init_rd_data", rd_data, 0);
        rst_n = 1'b1;

        // in_valid ignored in IDLE
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 0, 0, rand_row());

        // Full run with recognisable row values
        step(1'b0, 1'b1, 1'b0, 0, 0, '0);
        for (int r = 0; r < ROWS; r++) step(1'b1, 1'b0, 1'b0, 0, 0, mk_row(r));
        idle(6);
        step(1'b0, 1'b0, 1'b1, 2, 3, '0);
        chk("rd_2_3_valid", rd_valid, 1);
        chk("rd_2_3_data", rd_data, 16'h2300);
        read_all();

        // Gapped in_valid at relative cycles 0,2,5,6
        step(1'b0, 1'b1, 1'b0, 0, 0, '0);
        step(1'b1, 1'b0, 1'b0, 0, 0, rand_row());
        idle(1);
        step(1'b1, 1'b0, 1'b0, 0, 0, rand_row());
        idle(2);
        step(1'b1, 1'b0, 1'b0, 0, 0, rand_row());
        step(1'b1, 1'b0, 1'b0, 0, 0, rand_row());
        idle(6);
        read_all();

        // Fifth in_valid while lane 0 is full -> overflow, buffer unchanged
        step(1'b0, 1'b1, 1'b0, 0, 0, '0);
        for (int r = 0; r < ROWS + 1; r++) step(1'b1, 1'b0, 1'b0, 0, 0, mk_row(r + 5));
        idle(5);
        chk("ovf_sticky", overflow, 1);
        read_all();
        step(1'b0, 1'b1, 1'b1, 1, 1, '0);
        read_all();

        // Reset two cycles into capture
        step(1'b0, 1'b1, 1'b0, 0, 0, '0);
        step(1'b1, 1'b0, 1'b0, 0, 0, mk_row(1));
        step(1'b1, 1'b0, 1'b0, 0, 0, mk_row(2));
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 0, 0, rand_row());
        read_all();

        // start together with in_valid: element dropped
        step(1'b1, 1'b1, 1'b0, 0, 0, mk_row(7));
        idle(3);
        step(1'b0, 1'b0, 1'b1, 0, 0, '0);
        chk("start_drop_0_0", rd_data, 0);

        // Same-cycle read of the entry being written, then back-to-back reads in DONE
        step(1'b0, 1'b1, 1'b0, 0, 0, '0);
        step(1'b1, 1'b0, 1'b1, 0, 0, mk_row(3));
        step(1'b1, 1'b0, 1'b1, 0, 1, mk_row(4));
        step(1'b1, 1'b0, 1'b1, 1, 1, mk_row(5));
        step(1'b1, 1'b0, 1'b0, 0, 0, mk_row(6));
        idle(5);
        step(1'b0, 1'b0, 1'b1, 0, 0, '0);
        step(1'b0, 1'b0, 1'b1, 1, 2, '0);
        step(1'b0, 1'b0, 1'b1, 2, 1, '0);
        step(1'b0, 1'b0, 1'b1, 3, 3, '0);
        idle(2);

        // Randomized traffic including restarts and overflow windows
        for (int n = 0; n < 400; n++) begin
            rv = ($urandom_range(0, 3) != 0);
            rs = ($urandom_range(0, 59) == 0);
            rq = ($urandom_range(0, 1) == 1);
            step(rv, rs, rq, $urandom_range(0, ROWS - 1), $urandom_range(0, DIM - 1), rand_row());
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
